pipeline_event_monitor: RTL and testbench
=========================================

# pipeline_event_monitor

Synthesizable, parametrised event-counting monitor for the pipelined CPU. Counts elapsed run cycles and up to `NUM_CH` single-bit pipeline events (stall, flush, branch-taken, …). Stops itself after a programmable cycle limit. Exposes any counter through a registered read port, so stall/flush statistics are available in hardware and in gate-level simulation, not only from bench-side hierarchical peeks. Instantiated beside `CPU`, driven by the same clock, reset and start.

## Interface
- `NUM_CH`, 2: number of event channels.
- `CNT_W`, 32: width of every counter, cycle counter included.
- `CYCLE_LIMIT`, 30: run cycles before auto-stop; 0 = no limit; must be < 2^`CNT_W`.
- `SEL_W`, $clog2(`NUM_CH`+1): read-select width (derived, not overridden).

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  level; counting enabled while high.
- `clear_i`  in  1  synchronous pulse; zero all counters and overflow flags, return to IDLE.
- `event_i`  in  `NUM_CH`  bit n high = channel n event this cycle.
- `rd_sel_i`  in  `SEL_W`  0..`NUM_CH`-1 = event channel; `NUM_CH` = cycle counter; others read 0.
- `rd_data_o`  out  `CNT_W`  selected counter, registered.
- `overflow_o`  out  `NUM_CH`+1  sticky per-counter overflow; bit `NUM_CH` = cycle counter.
- `state_o`  out  2  00 IDLE, 01 RUN, 10 DONE.
- `done_o`  out  1  high in DONE.

## Operation
- States:
  - IDLE: counters hold.
  - RUN: cycle counter +1 every cycle; channel n +1 when `event_i[n]`=1.
  - DONE: all counters frozen.
- Transitions:
  - IDLE→RUN when `start_i`=1. That cycle is not counted; counting begins on the first RUN cycle.
  - RUN→IDLE when `start_i`=0 (pause; values retained; resuming continues counting).
  - RUN→DONE on the edge where the cycle counter goes from `CYCLE_LIMIT`-1 to `CYCLE_LIMIT`. Events in that final cycle are counted.
  - With `CYCLE_LIMIT`=0, DONE is never entered.
  - DONE exits only via `clear_i` or `rst_i`; `start_i` is ignored.
- Priority: `rst_i` > `clear_i` > limit > `start_i`. An event in the same cycle as `clear_i` is dropped; counters read 0 after that edge.
- Counter increment at max value 2^`CNT_W`-1 wraps to 0 and sets the matching `overflow_o` bit. The bit stays set until clear or reset.
- Read port: `rd_data_o` samples the selected counter's pre-update value at each edge.

## Timing
- Reset values: all counters 0, `rd_data_o`=0, `overflow_o`=0, `state_o`=IDLE, `done_o`=0. Reset is asynchronous on assertion and may hit mid-RUN or in DONE with the same result.
- Read latency 1 cycle: `rd_sel_i` changed before edge k gives the new counter on `rd_data_o` after edge k, showing the value held during the cycle before k.
- `done_o` and `state_o` are registered; `done_o` rises on the edge that completes the `CYCLE_LIMIT`-th RUN cycle.
- No combinational path from inputs to outputs.

## Configuration
- `PERF_SATURATE_EN` defined:
  - Counters saturate at 2^`CNT_W`-1 instead of wrapping.
  - The overflow bit sets on the first increment attempted at max.
  - The cycle counter saturating in RUN with `CYCLE_LIMIT`=0 keeps RUN.
- Undefined: wrap-around behaviour as above.

## Test plan
- Limit stop: defaults, `start_i`=1, `event_i`=2'b01 every cycle for 40 cycles → `done_o` rises after 30 RUN cycles; cycle=30, ch0=30, ch1=0; further events leave values unchanged.
- Pause: `start_i` high 5 cycles, low 3, high 4, `event_i`=2'b11 throughout → cycle=9, ch0=9, ch1=9, `state_o`=IDLE during the gap.
- Overflow, `CNT_W`=4, `CYCLE_LIMIT`=0, 17 ch0 events:
  - Without macro → ch0=1, `overflow_o[0]`=1.
  - With `PERF_SATURATE_EN` → ch0=15, `overflow_o[0]`=1.
- Clear collision: in DONE, assert `clear_i` with `event_i`=2'b11 → next edge all counters 0, `overflow_o`=0, IDLE, `done_o`=0.
- Async reset mid-RUN: drop `rst_i` between edges at cycle 12 → outputs 0 immediately. After release with `start_i`=1, counting restarts from 0.
- Read latency: switch `rd_sel_i` from 0 to 2 (`NUM_CH`=2) while running → `rd_data_o` shows the cycle count after exactly one edge. `rd_sel_i`=3 → 0.

Source files
------------

// File: rtl/pipeline_event_monitor.sv
// rtl/pipeline_event_monitor.sv - cycle/event counting monitor with cycle-limit auto-stop and registered read port (optional macro: PERF_SATURATE_EN)
module pipeline_event_monitor #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30,
    localparam int SEL_W      = $clog2(NUM_CH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [NUM_CH-1:0] event_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic [NUM_CH:0]   overflow_o,
    output logic [1:0]        state_o,
    output logic              done_o
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);
    localparam bit               LIMIT_EN = (CYCLE_LIMIT != 0);

    // Index NUM_CH holds the cycle counter; lower indices are event channels.
    logic [CNT_W-1:0] cnt_q   [NUM_CH+1];
    logic [CNT_W-1:0] cnt_nxt [NUM_CH+1];
    logic [NUM_CH:0]  ovf_q;
    logic [NUM_CH:0]  ovf_nxt;
    logic [NUM_CH:0]  inc;
    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_mux;
    logic             run;
    logic             hit_limit;

    // Next counter values and overflow flags; counting only happens in RUN.
    always_comb begin
        run = (state_q == ST_RUN);
        inc = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            inc[n] = run & event_i[n];
        end
        inc[NUM_CH] = run;
        ovf_nxt = ovf_q;
        for (int i = 0; i <= NUM_CH; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (inc[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_nxt[i] = 1'b1;
`ifdef PERF_SATURATE_EN
                    cnt_nxt[i] = CNT_MAX;
`else
                    cnt_nxt[i] = '0;
`endif
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Mode sequencing: the limit check wins over a dropped start in the same cycle.
    always_comb begin
        hit_limit = LIMIT_EN && run && (cnt_q[NUM_CH] == LIMIT_M1);
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_nxt = ST_RUN;
            ST_RUN: begin
                if (hit_limit)     state_nxt = ST_DONE;
                else if (!start_i) state_nxt = ST_IDLE;
            end
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read mux over current (pre-update) counter values; unused selects read zero.
    always_comb begin
        rd_mux = '0;
        if (int'(rd_sel_i) <= NUM_CH) begin
            rd_mux = cnt_q[rd_sel_i];
        end
    end

    // State, counters, flags and read register; clear outranks every update.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i <= NUM_CH; i++) cnt_q[i] <= '0;
            ovf_q     <= '0;
            state_q   <= ST_IDLE;
            rd_data_q <= '0;
        end else if (clear_i) begin
            for (int i = 0; i <= NUM_CH; i++) cnt_q[i] <= '0;
            ovf_q     <= '0;
            state_q   <= ST_IDLE;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i <= NUM_CH; i++) cnt_q[i] <= cnt_nxt[i];
            ovf_q     <= ovf_nxt;
            state_q   <= state_nxt;
            rd_data_q <= rd_mux;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign overflow_o = ovf_q;
    assign state_o    = state_q;
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_pipeline_event_monitor.sv
// tb/tb_pipeline_event_monitor.sv - directed self-checking bench for pipeline_event_monitor
module tb_pipeline_event_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear;
    logic [1:0]  ev;
    logic [1:0]  rd_sel;
    logic [31:0] rd_data;
    logic [2:0]  ovf;
    logic [1:0]  state;
    logic        done;

    logic        s_start, s_clear;
    logic [1:0]  s_ev;
    logic [1:0]  s_rd_sel;
    logic [3:0]  s_rd_data;
    logic [2:0]  s_ovf;
    logic [1:0]  s_state;
    logic        s_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_event_monitor dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .event_i(ev), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
        .overflow_o(ovf), .state_o(state), .done_o(done)
    );

    pipeline_event_monitor #(.NUM_CH(2), .CNT_W(4), .CYCLE_LIMIT(0)) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(s_clear),
        .event_i(s_ev), .rd_sel_i(s_rd_sel), .rd_data_o(s_rd_data),
        .overflow_o(s_ovf), .state_o(s_state), .done_o(s_done)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_main(input logic [1:0] sel, output logic [31:0] v);
        rd_sel = sel;
        step();
        v = rd_data;
    endtask

    task automatic read_small(input logic [1:0] sel, output logic [3:0] v);
        s_rd_sel = sel;
        step();
        v = s_rd_data;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
        checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL reset_overflow: got %b expected 000", ovf); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_limit_stop();
        logic [31:0] v;
        do_clear();
        start = 1'b1;
        ev = 2'b01;
        step();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL limit_enter_run: got %b expected 01", state); end
        repeat (29) step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL limit_done_early: got %b expected 0", done); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL limit_done_rise: got %b expected 1", done); end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL limit_state_done: got %b expected 10", state); end
        repeat (9) step();
        start = 1'b0;
        ev = 2'b00;
        read_main(2'd2, v);
        checks++; if (v !== 32'd30) begin errors++; $display("FAIL limit_cycle: got %0d expected 30", v); end
        read_main(2'd0, v);
        checks++; if (v !== 32'd30) begin errors++; $display("FAIL limit_ch0: got %0d expected 30", v); end
        read_main(2'd1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL limit_ch1: got %0d expected 0", v); end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL limit_stays_done: got %b expected 10", state); end
    endtask

    task automatic test_clear_collision();
        logic [31:0] v;
        clear = 1'b1;
        ev = 2'b11;
        step();
        clear = 1'b0;
        ev = 2'b00;
        checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL clear_overflow: got %b expected 000", ovf); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL clear_state: got %b expected 00", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clear_done: got %b expected 0", done); end
        for (int s = 0; s < 3; s++) begin
            read_main(2'(s), v);
            checks++; if (v !== 32'd0) begin errors++; $display("FAIL clear_counter%0d: got %0d expected 0", s, v); end
        end
    endtask

    task automatic test_pause();
        logic [31:0] v;
        do_clear();
        start = 1'b1;
        ev = 2'b11;
        repeat (5) step();
        start = 1'b0;
        for (int g = 0; g < 3; g++) begin
            step();
            checks++; if (state !== 2'b00) begin errors++; $display("FAIL pause_gap_state%0d: got %b expected 00", g, state); end
        end
        start = 1'b1;
        repeat (4) step();
        start = 1'b0;
        step();
        ev = 2'b00;
        read_main(2'd2, v);
        checks++; if (v !== 32'd9) begin errors++; $display("FAIL pause_cycle: got %0d expected 9", v); end
        read_main(2'd0, v);
        checks++; if (v !== 32'd9) begin errors++; $display("FAIL pause_ch0: got %0d expected 9", v); end
        read_main(2'd1, v);
        checks++; if (v !== 32'd9) begin errors++; $display("FAIL pause_ch1: got %0d expected 9", v); end
    endtask

    task automatic test_read_latency();
        do_clear();
        rd_sel = 2'd0;
        ev = 2'b00;
        start = 1'b1;
        step();
        repeat (3) step();
        rd_sel = 2'd2;
        #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL read_before_edge: got %0d expected 0", rd_data); end
        @(negedge clk);
        checks++; if (rd_data !== 32'd3) begin errors++; $display("FAIL read_after_edge: got %0d expected 3", rd_data); end
        rd_sel = 2'd3;
        step();
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL read_sel3: got %0d expected 0", rd_data); end
        start = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        logic [3:0] v;
        logic [3:0] exp_ch0, exp_cyc;
`ifdef PERF_SATURATE_EN
        exp_ch0 = 4'd15;
        exp_cyc = 4'd15;
`else
        exp_ch0 = 4'd1;
        exp_cyc = 4'd2;
`endif
        s_start = 1'b1;
        step();
        s_ev = 2'b01;
        repeat (17) step();
        s_start = 1'b0;
        s_ev = 2'b00;
        step();
        read_small(2'd0, v);
        checks++; if (v !== exp_ch0) begin errors++; $display("FAIL overflow_ch0: got %0d expected %0d", v, exp_ch0); end
        read_small(2'd2, v);
        checks++; if (v !== exp_cyc) begin errors++; $display("FAIL overflow_cycle: got %0d expected %0d", v, exp_cyc); end
        checks++; if (s_ovf !== 3'b101) begin errors++; $display("FAIL overflow_flags: got %b expected 101", s_ovf); end
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL overflow_no_done: got %b expected 0", s_done); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        do_clear();
        rd_sel = 2'd2;
        start = 1'b1;
        step();
        repeat (12) step();
        checks++; if (rd_data !== 32'd11) begin errors++; $display("FAIL areset_pre_read: got %0d expected 11", rd_data); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL areset_rd_data: got %0d expected 0", rd_data); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL areset_state: got %b expected 00", state); end
        checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL areset_overflow: got %b expected 000", ovf); end
        @(negedge clk);
        rst = 1'b1;
        step();
        repeat (5) step();
        start = 1'b0;
        step();
        read_main(2'd2, v);
        checks++; if (v !== 32'd6) begin errors++; $display("FAIL areset_restart_cycle: got %0d expected 6", v); end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0; clear = 1'b0; ev = 2'b00; rd_sel = 2'd0;
        s_start = 1'b0; s_clear = 1'b0; s_ev = 2'b00; s_rd_sel = 2'd0;
        test_reset();
        test_limit_stop();
        test_clear_collision();
        test_pause();
        test_read_latency();
        test_overflow();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
